// File: rtl/vga_pkg.sv
// Purpose : shared VGA timing constants (800x600 @ 60 Hz, 40 MHz pixel clock) and count type.
// Latency : n/a (constants and types only).
// Backpressure: n/a.
`timescale 1ns/1ps
package vga_pkg;

  localparam int HOR_PIXELS = 800;   // visible pixels per line
  localparam int VER_PIXELS = 600;   // visible lines per frame

  localparam int H_TOTAL  = 1056;
  localparam int HS_START = 840;
  localparam int HS_LEN   = 128;

  localparam int V_TOTAL  = 628;
  localparam int VS_START = 601;
  localparam int VS_LEN   = 4;

  typedef logic [10:0] vga_cnt_t;

endpackage

// File: rtl/vga_if.sv
// Purpose : pixel-stream bundle passed between the timing source and the draw stages.
// Latency : n/a (wiring only).
// Backpressure: none; the stream advances with the pixel clock enable of the source.
// Signals : hcount/vcount, hsync/vsync, hblnk/vblnk, rgb[11:0].
`timescale 1ns/1ps
interface vga_if;
  import vga_pkg::*;

  vga_cnt_t    hcount;
  vga_cnt_t    vcount;
  logic        hsync;
  logic        vsync;
  logic        hblnk;
  logic        vblnk;
  logic [11:0] rgb;

  // Source / sink views. out/in are the names used by the video pipeline;
  // master/slave are the same views under the generic names.
  modport out    (output hcount, vcount, hsync, vsync, hblnk, vblnk, rgb);
  modport in     (input  hcount, vcount, hsync, vsync, hblnk, vblnk, rgb);
  modport master (output hcount, vcount, hsync, vsync, hblnk, vblnk, rgb);
  modport slave  (input  hcount, vcount, hsync, vsync, hblnk, vblnk, rgb);

endinterface

// File: rtl/vga_axis_cnt.sv
// Purpose : one timing axis: wrapping counter plus registered blank and (active-high) sync flags.
// Latency : flags registered from the next count, so they line up with cnt (0 cycles of skew).
// Backpressure: counter holds while inc=0.
// Ports   : clk, rst_n (async, active-low), inc (advance), cnt (count), wrap (inc on last count,
//           combinational), blnk (cnt >= ACTIVE), sync (S_START <= cnt < S_START+S_LEN).
`timescale 1ns/1ps
module vga_axis_cnt
  import vga_pkg::*;
#(
  parameter int TOTAL   = H_TOTAL,
  parameter int ACTIVE  = HOR_PIXELS,
  parameter int S_START = HS_START,
  parameter int S_LEN   = HS_LEN
) (
  input  logic     clk,
  input  logic     rst_n,
  input  logic     inc,
  output vga_cnt_t cnt,
  output logic     wrap,
  output logic     blnk,
  output logic     sync
);

  if (!((ACTIVE < S_START) && (S_START + S_LEN <= TOTAL) && (TOTAL <= 2048))) begin : g_param_chk
    $error("vga_axis_cnt: need ACTIVE < S_START, S_START+S_LEN <= TOTAL, TOTAL <= 2048");
  end

  localparam vga_cnt_t    C_LAST   = vga_cnt_t'(TOTAL - 1);
  localparam vga_cnt_t    C_ACTIVE = vga_cnt_t'(ACTIVE);
  localparam vga_cnt_t    C_SSTART = vga_cnt_t'(S_START);
  // Sync end may equal TOTAL (up to 2048), so it needs one extra bit.
  localparam logic [11:0] C_SEND   = 12'(S_START + S_LEN);

  vga_cnt_t r_cnt;
  vga_cnt_t w_cnt_nxt;
  logic     r_blnk;
  logic     r_sync;

  assign wrap = inc && (r_cnt == C_LAST);

  always_comb begin
    w_cnt_nxt = r_cnt;
    if (inc) begin
      w_cnt_nxt = (r_cnt == C_LAST) ? '0 : r_cnt + 11'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt  <= '0;
      r_blnk <= 1'b0;
      r_sync <= 1'b0;
    end else begin
      r_cnt  <= w_cnt_nxt;
      r_blnk <= (w_cnt_nxt >= C_ACTIVE);
      r_sync <= (w_cnt_nxt >= C_SSTART) && ({1'b0, w_cnt_nxt} < C_SEND);
    end
  end

  assign cnt  = r_cnt;
  assign blnk = r_blnk;
  assign sync = r_sync;

endmodule

// File: rtl/vga_timing_gen.sv
// Purpose : head of the video pipeline; drives hcount/vcount, syncs, blanks, rgb=0, line/frame pulses, frame count.
// Latency : all outputs registered and mutually aligned; first enabled cycle after reset gives hcount=1.
// Backpressure: en=0 freezes every output and forces the pulses low.
// Ports   : clk, rst_n (async, active-low), en, tim_out (vga_if.out), line_start, frame_start, frame_cnt[15:0].
`timescale 1ns/1ps
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int   H_ACTIVE = HOR_PIXELS,
  parameter int   H_TOT    = H_TOTAL,
  parameter int   HS_BEGIN = HS_START,
  parameter int   HS_WIDTH = HS_LEN,
  parameter int   V_ACTIVE = VER_PIXELS,
  parameter int   V_TOT    = V_TOTAL,
  parameter int   VS_BEGIN = VS_START,
  parameter int   VS_WIDTH = VS_LEN,
  parameter logic SYNC_POL = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  vga_if.out          tim_out,
  output logic        line_start,
  output logic        frame_start,
  output logic [15:0] frame_cnt
);

  vga_cnt_t    w_hcount;
  vga_cnt_t    w_vcount;
  logic        w_h_wrap;
  logic        w_v_wrap;
  logic        w_hblnk;
  logic        w_vblnk;
  logic        w_hsync;
  logic        w_vsync;

  logic        r_line_start;
  logic        r_frame_start;
  logic [15:0] r_frame_cnt;
  logic [11:0] r_rgb;

  vga_axis_cnt #(
    .TOTAL(H_TOT), .ACTIVE(H_ACTIVE), .S_START(HS_BEGIN), .S_LEN(HS_WIDTH)
  ) u_hcnt (
    .clk(clk), .rst_n(rst_n), .inc(en),
    .cnt(w_hcount), .wrap(w_h_wrap), .blnk(w_hblnk), .sync(w_hsync)
  );

  // The line counter only moves on the last pixel of a line.
  vga_axis_cnt #(
    .TOTAL(V_TOT), .ACTIVE(V_ACTIVE), .S_START(VS_BEGIN), .S_LEN(VS_WIDTH)
  ) u_vcnt (
    .clk(clk), .rst_n(rst_n), .inc(en & w_h_wrap),
    .cnt(w_vcount), .wrap(w_v_wrap), .blnk(w_vblnk), .sync(w_vsync)
  );

  // w_v_wrap already implies en & w_h_wrap, so it marks the last pixel of the frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_line_start  <= 1'b0;
      r_frame_start <= 1'b0;
      r_frame_cnt   <= '0;
      r_rgb         <= '0;
    end else begin
      r_line_start  <= w_h_wrap;
      r_frame_start <= w_v_wrap;
      r_rgb         <= '0;
      if (w_v_wrap) begin
        r_frame_cnt <= r_frame_cnt + 16'd1;
      end
    end
  end

  // Axis sync flags are active-high internally; reset (flag 0) therefore gives ~SYNC_POL.
  assign tim_out.hcount = w_hcount;
  assign tim_out.vcount = w_vcount;
  assign tim_out.hsync  = w_hsync ? SYNC_POL : ~SYNC_POL;
  assign tim_out.vsync  = w_vsync ? SYNC_POL : ~SYNC_POL;
  assign tim_out.hblnk  = w_hblnk;
  assign tim_out.vblnk  = w_vblnk;
  assign tim_out.rgb    = r_rgb;

  assign line_start  = r_line_start;
  assign frame_start = r_frame_start;
  assign frame_cnt   = r_frame_cnt;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Purpose : directed bench for vga_timing_gen: line, frame, sync polarity, enable hold, async reset, frame_cnt wrap.
// Latency : outputs sampled on the falling edge, half a cycle after the rising edge that updates them.
// Backpressure: en driven directly by the stimulus.
// dut_a: full 800x600 timing, SYNC_POL=1. dut_c: same timing, SYNC_POL=0.
// dut_b: 16-clock lines (active 8, hsync 10..12), full vertical timing, so a frame is 10048 cycles.
`timescale 1ns/1ps
module tb_vga_timing_gen;

  logic        clk;
  logic        rst_n;
  logic        en;

  logic        ls_a, fs_a, ls_b, fs_b, ls_c, fs_c;
  logic [15:0] fc_a, fc_b, fc_c;

  vga_if if_a ();
  vga_if if_b ();
  vga_if if_c ();

  vga_timing_gen dut_a (
    .clk(clk), .rst_n(rst_n), .en(en), .tim_out(if_a),
    .line_start(ls_a), .frame_start(fs_a), .frame_cnt(fc_a)
  );

  vga_timing_gen #(
    .H_ACTIVE(8), .H_TOT(16), .HS_BEGIN(10), .HS_WIDTH(3)
  ) dut_b (
    .clk(clk), .rst_n(rst_n), .en(en), .tim_out(if_b),
    .line_start(ls_b), .frame_start(fs_b), .frame_cnt(fc_b)
  );

  vga_timing_gen #(
    .SYNC_POL(1'b0)
  ) dut_c (
    .clk(clk), .rst_n(rst_n), .en(en), .tim_out(if_c),
    .line_start(ls_c), .frame_start(fs_c), .frame_cnt(fc_c)
  );

  initial clk = 1'b0;
  always #12.5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  // Reference position of dut_a/dut_c (ah, av) and dut_b (bh, bv).
  int ah = 0, av = 0, bh = 0, bv = 0;

  task automatic check(input string tag, input int got, input int exp);
    n_chk++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  // One clock: the rising edge happens, then we sit on the falling edge.
  task automatic cycle();
    @(negedge clk);
    if (en && rst_n) begin
      if (ah == 1055) begin
        ah = 0;
        av = (av == 627) ? 0 : av + 1;
      end else begin
        ah++;
      end
      if (bh == 15) begin
        bh = 0;
        bv = (bv == 627) ? 0 : bv + 1;
      end else begin
        bh++;
      end
    end
  endtask

  initial begin
    int bad, ls_n, ls_i, hb_first, hb_n, hs_n, hs_first, hs_last, c_bad;
    int fs_n, fs_h, fs_v, vs_min, vs_max, vs_bad, vb_bad, n;
    bit reached;

    rst_n = 1'b0;
    en    = 1'b0;
    repeat (3) @(negedge clk);

    // Reset state
    check("rst_hcount", if_a.hcount, 0);
    check("rst_vcount", if_a.vcount, 0);
    check("rst_hsync", if_a.hsync, 0);
    check("rst_vsync", if_a.vsync, 0);
    check("rst_hsync_pol0", if_c.hsync, 1);
    check("rst_hblnk", if_a.hblnk, 0);
    check("rst_vblnk", if_a.vblnk, 0);
    check("rst_rgb", if_a.rgb, 0);
    check("rst_line_start", ls_a, 0);
    check("rst_frame_start", fs_a, 0);
    check("rst_frame_cnt", fc_a, 0);

    // Tests 1 and 3: one full line on dut_a / dut_c
    rst_n = 1'b1;
    en    = 1'b1;
    bad = 0; ls_n = 0; ls_i = -1; hb_first = -1; hb_n = 0;
    hs_n = 0; hs_first = -1; hs_last = -1; c_bad = 0;
    for (int i = 1; i <= 1056; i++) begin
      cycle();
      if (int'(if_a.hcount) != ah || int'(if_a.vcount) != av) bad++;
      if (ls_a) begin ls_n++; ls_i = i; end
      if (if_a.hblnk) begin
        hb_n++;
        if (hb_first < 0) hb_first = int'(if_a.hcount);
      end
      if (if_a.hsync) begin
        hs_n++;
        if (hs_first < 0) hs_first = int'(if_a.hcount);
        hs_last = int'(if_a.hcount);
      end
      if (if_c.hsync != !(ah >= 840 && ah < 968)) c_bad++;
    end
    check("t1_count_seq_bad", bad, 0);
    check("t1_end_hcount", if_a.hcount, 0);
    check("t1_end_vcount", if_a.vcount, 1);
    check("t1_line_start_n", ls_n, 1);
    check("t1_line_start_cycle", ls_i, 1056);
    check("t1_hblnk_first", hb_first, 800);
    check("t1_hblnk_n", hb_n, 256);
    check("t3_hsync_n", hs_n, 128);
    check("t3_hsync_first", hs_first, 840);
    check("t3_hsync_last", hs_last, 967);
    check("t3_pol0_hsync_bad", c_bad, 0);

    // Test 2: complete one frame on dut_b
    n = 16 * 628 - (bv * 16 + bh) + 20;
    bad = 0; fs_n = 0; fs_h = -1; fs_v = -1; vs_min = -1; vs_max = -1; vs_bad = 0; vb_bad = 0;
    for (int i = 0; i < n; i++) begin
      cycle();
      if (int'(if_b.hcount) != bh || int'(if_b.vcount) != bv) bad++;
      if (fs_b) begin
        fs_n++;
        fs_h = int'(if_b.hcount);
        fs_v = int'(if_b.vcount);
      end
      if (if_b.vsync) begin
        if (vs_min < 0) vs_min = int'(if_b.vcount);
        vs_max = int'(if_b.vcount);
      end
      if (if_b.vsync != (bv >= 601 && bv <= 604)) vs_bad++;
      if (if_b.vblnk != (bv >= 600)) vb_bad++;
    end
    check("t2_count_seq_bad", bad, 0);
    check("t2_frame_start_n", fs_n, 1);
    check("t2_frame_start_h", fs_h, 0);
    check("t2_frame_start_v", fs_v, 0);
    check("t2_frame_cnt", fc_b, 1);
    check("t2_vsync_first", vs_min, 601);
    check("t2_vsync_last", vs_max, 604);
    check("t2_vsync_bad", vs_bad, 0);
    check("t2_vblnk_bad", vb_bad, 0);

    // Test 4: en 1,0,0,1 around hcount=1055 on dut_a
    reached = 1'b0;
    for (int i = 0; i < 1100; i++) begin
      if (ah == 1054) begin reached = 1'b1; break; end
      cycle();
    end
    check("t4_reach_1054", if_a.hcount, 1054);
    en = 1'b1; cycle();
    check("t4_h_1055", if_a.hcount, 1055);
    en = 1'b0; cycle();
    check("t4_hold1_h", if_a.hcount, 1055);
    check("t4_hold1_ls", ls_a, 0);
    cycle();
    check("t4_hold2_h", if_a.hcount, 1055);
    check("t4_hold2_ls", ls_a, 0);
    en = 1'b1; cycle();
    check("t4_wrap_h", if_a.hcount, 0);
    check("t4_wrap_ls", ls_a, 1);
    cycle();
    check("t4_after_ls", ls_a, 0);

    // Test 5: async reset mid-frame on dut_b at (5,300)
    for (int i = 0; i < 12000; i++) begin
      if (bv == 300 && bh == 5) break;
      cycle();
    end
    check("t5_pre_h", if_b.hcount, 5);
    check("t5_pre_v", if_b.vcount, 300);
    #5 rst_n = 1'b0;
    #3;
    check("t5_async_h", if_b.hcount, 0);
    check("t5_async_v", if_b.vcount, 0);
    check("t5_async_frame_cnt", fc_b, 0);
    check("t5_async_hsync", if_b.hsync, 0);
    rst_n = 1'b1;
    ah = 0; av = 0; bh = 0; bv = 0;
    cycle();
    check("t5_first_h", if_b.hcount, 1);
    check("t5_first_v", if_b.vcount, 0);
    check("t5_first_ls", ls_b, 0);
    check("t5_a_first_h", if_a.hcount, 1);

    // Test 6: frame_cnt wrap from 16'hFFFF on dut_b
    force dut_b.r_frame_cnt = 16'hFFFF;
    cycle();
    release dut_b.r_frame_cnt;
    cycle();
    check("t6_forced", fc_b, 16'hFFFF);
    n = 16 * 628 - (bv * 16 + bh);
    fs_n = 0;
    for (int i = 0; i < n; i++) begin
      cycle();
      if (fs_b) fs_n++;
    end
    check("t6_wrap_h", if_b.hcount, 0);
    check("t6_wrap_v", if_b.vcount, 0);
    check("t6_frame_start", fs_b, 1);
    check("t6_frame_start_n", fs_n, 1);
    check("t6_frame_cnt", fc_b, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
